// File: rtl/task_pkg.sv
// Shared task constants: per-task packet sizes, task id type and size lookup.
package task_pkg;

  localparam int NUM_TASKS = 10;

  typedef logic [3:0] task_id_t;

  localparam logic [11:0] TASK1_SIZE  = 12'd81;
  localparam logic [11:0] TASK2_SIZE  = 12'd81;
  localparam logic [11:0] TASK3_SIZE  = 12'd27;
  localparam logic [11:0] TASK4_SIZE  = 12'd120;
  localparam logic [11:0] TASK5_SIZE  = 12'd256;
  localparam logic [11:0] TASK6_SIZE  = 12'd50;
  localparam logic [11:0] TASK7_SIZE  = 12'd50;
  localparam logic [11:0] TASK8_SIZE  = 12'd160;
  localparam logic [11:0] TASK9_SIZE  = 12'd40;
  localparam logic [11:0] TASK10_SIZE = 12'd64;

  // Index is 0-based; task N of the size table lives at index N-1.
  function automatic logic [11:0] task_size(input task_id_t id);
    case (id)
      4'd0:    return TASK1_SIZE;
      4'd1:    return TASK2_SIZE;
      4'd2:    return TASK3_SIZE;
      4'd3:    return TASK4_SIZE;
      4'd4:    return TASK5_SIZE;
      4'd5:    return TASK6_SIZE;
      4'd6:    return TASK7_SIZE;
      4'd7:    return TASK8_SIZE;
      4'd8:    return TASK9_SIZE;
      4'd9:    return TASK10_SIZE;
      default: return 12'd1;
    endcase
  endfunction

endpackage

// File: rtl/task_rr_picker.sv
// Combinational round-robin select: first candidate strictly after last_grant, wrapping.
module task_rr_picker
  import task_pkg::*;
#(
  parameter int N_REQ = NUM_TASKS
) (
  input  logic [N_REQ-1:0] cand_i,
  input  task_id_t         last_grant_i,
  output task_id_t         grant_o,
  output logic             found_o
);

  logic     hi_found;
  logic     lo_found;
  task_id_t hi_idx;
  task_id_t lo_idx;

  // Descending scan so the lowest index wins; "hi" covers indices above last_grant.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_i[i]) begin
        lo_found = 1'b1;
        lo_idx   = task_id_t'(i);
        if (i > int'(last_grant_i)) begin
          hi_found = 1'b1;
          hi_idx   = task_id_t'(i);
        end
      end
    end
    found_o = lo_found;
    grant_o = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/task_pkt_arbiter.sv
// Round-robin packet arbiter merging per-task byte streams into one stream.
// Optional per-task completed-packet counters when TASK_ARB_PKT_CNT_EN is defined.
module task_pkt_arbiter #(
  parameter int NUM_TASKS = task_pkg::NUM_TASKS,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_TASKS-1:0]        task_en_i,
  input  logic [NUM_TASKS-1:0]        req_valid_i,
  input  logic [NUM_TASKS*DATA_W-1:0] req_data_i,
  output logic [NUM_TASKS-1:0]        req_ready_o,
  output logic                        m_valid_o,
  output logic [DATA_W-1:0]           m_data_o,
  output logic                        m_last_o,
  output logic [3:0]                  m_task_o,
  input  logic                        m_ready_i,
`ifdef TASK_ARB_PKT_CNT_EN
  output logic [NUM_TASKS*16-1:0]     pkt_cnt_o,
`endif
  output logic                        busy_o
);

  import task_pkg::*;

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state_q, state_d;
  task_id_t    grant_q, grant_d;
  task_id_t    last_grant_q, last_grant_d;
  logic [8:0]  cnt_q, cnt_d;

  task_id_t    pick_grant;
  logic        pick_found;
  logic        sel_valid;
  logic        is_last;
  logic        hs;
  logic [DATA_W-1:0] lane [NUM_TASKS];

  for (genvar g = 0; g < NUM_TASKS; g++) begin : g_lane
    assign lane[g] = req_data_i[g*DATA_W +: DATA_W];
  end

  task_rr_picker #(.N_REQ(NUM_TASKS)) u_picker (
    .cand_i       (req_valid_i & task_en_i),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .found_o      (pick_found)
  );

  assign sel_valid = req_valid_i[grant_q];
  assign is_last   = ({3'b000, cnt_q} == (task_size(grant_q) - 12'd1));
  assign hs        = (state_q == XFER) && sel_valid && m_ready_i;
  assign m_task_o  = grant_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    m_valid_o    = 1'b0;
    m_data_o     = '0;
    m_last_o     = 1'b0;
    req_ready_o  = '0;
    busy_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_grant;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        busy_o               = 1'b1;
        m_valid_o            = sel_valid;
        m_data_o             = lane[grant_q];
        m_last_o             = sel_valid && is_last;
        req_ready_o[grant_q] = m_ready_i;
        if (hs) begin
          cnt_d = cnt_q + 9'd1;
          if (is_last) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= task_id_t'(NUM_TASKS - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef TASK_ARB_PKT_CNT_EN
  logic        pkt_done;
  logic [15:0] pkt_cnt_q [NUM_TASKS];
  logic [15:0] pkt_cnt_d [NUM_TASKS];

  assign pkt_done = hs && is_last;

  always_comb begin
    for (int i = 0; i < NUM_TASKS; i++) pkt_cnt_d[i] = pkt_cnt_q[i];
    if (pkt_done) pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TASKS; i++) pkt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TASKS; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_TASKS; g++) begin : g_cnt_out
    assign pkt_cnt_o[g*16 +: 16] = pkt_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_task_pkt_arbiter.sv
// Directed, table-driven bench for task_pkt_arbiter with a per-task byte source model.
module tb_task_pkt_arbiter;

  localparam int NT = 10;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NT-1:0]     task_en_i = '0;
  logic [NT-1:0]     req_valid_i = '0;
  logic [NT*DW-1:0]  req_data_i = '0;
  logic [NT-1:0]     req_ready_o;
  logic              m_valid_o;
  logic [DW-1:0]     m_data_o;
  logic              m_last_o;
  logic [3:0]        m_task_o;
  logic              m_ready_i = 1'b0;
  logic              busy_o;
`ifdef TASK_ARB_PKT_CNT_EN
  logic [NT*16-1:0]  pkt_cnt_o;
`endif

  always #5 clk = ~clk;

  task_pkt_arbiter #(.NUM_TASKS(NT), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .task_en_i   (task_en_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .m_task_o    (m_task_o),
    .m_ready_i   (m_ready_i),
`ifdef TASK_ARB_PKT_CNT_EN
    .pkt_cnt_o   (pkt_cnt_o),
`endif
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [NT-1:0] en;
    logic [NT-1:0] valid;
    int            exp_task;
    int            exp_len;
  } vec_t;

  int            n_checks = 0;
  int            n_fail = 0;
  int            src_cnt [NT];
  int            exp_pkts [NT];
  int            sizes [NT] = '{81, 81, 27, 120, 256, 50, 50, 160, 40, 64};
  logic [NT-1:0] want_valid = '0;
  bit            toggle_ready = 1'b0;
  int            drop_task = -1;
  int            drop_at = 0;
  int            drop_left = 0;
  bit            gate = 1'b0;
  int            last_low = 0;
  logic          s_busy, s_valid, s_last, s_hs;
  logic [3:0]    s_task;

  function automatic logic [7:0] pattern(int t, int n);
    return 8'((n * 7 + t * 31) & 255);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int t = 0; t < NT; t++) begin
      req_valid_i[t] = want_valid[t] & ~(gate && (t == drop_task));
      req_data_i[t*DW +: DW] = pattern(t, src_cnt[t]);
    end
  endtask

  task automatic applyStimulus(input logic [NT-1:0] en, input logic [NT-1:0] valid, input logic rdy);
    task_en_i  = en;
    want_valid = valid;
    m_ready_i  = rdy;
    drive();
  endtask

  // One clock: sample at negedge, then advance the source model after the edge.
  task automatic step();
    int tk;
    @(negedge clk);
    s_busy  = busy_o;
    s_valid = m_valid_o;
    s_last  = m_last_o;
    s_task  = m_task_o;
    s_hs    = m_valid_o & m_ready_i;
    tk      = int'(m_task_o);
    if (s_hs) begin
      if (tk < NT) begin
        checkOutput("byte_data", 32'(m_data_o), 32'(pattern(tk, src_cnt[tk])));
        checkOutput("ready_onehot", 32'(req_ready_o), 32'(1 << tk));
      end else begin
        checkOutput("task_range", 32'(tk), 32'(NT - 1));
      end
    end
    @(posedge clk);
    #1;
    if (s_hs && tk < NT) src_cnt[tk]++;
    if (toggle_ready) m_ready_i = ~m_ready_i;
    if (drop_left > 0 && drop_task >= 0 && src_cnt[drop_task] == drop_at) begin
      gate = 1'b1;
      drop_left--;
    end else begin
      gate = 1'b0;
    end
    drive();
  endtask

  task automatic run_packet(input int exp_task, input int exp_len, input string name);
    int   hs = 0;
    int   cyc = 0;
    int   low = 0;
    bit   done = 1'b0;
    bit   chg = 1'b0;
    bit   started = 1'b0;
    logic [3:0] first = 4'hF;
    step();
    checkOutput({name, "_gap"}, 32'(s_busy), 32'd0);
    while (!done && cyc < 3000) begin
      step();
      if (cyc == 0) checkOutput({name, "_start"}, 32'(s_busy), 32'd1);
      cyc++;
      if (s_busy) begin
        if (!started) begin
          started = 1'b1;
          first   = s_task;
        end else if (s_task != first) begin
          chg = 1'b1;
        end
        if (!s_valid) low++;
      end
      if (s_hs) begin
        hs++;
        if (s_last) done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got no last byte after %0d cycles, expected one", name, cyc);
    end
    checkOutput({name, "_task"}, 32'(first), 32'(exp_task));
    checkOutput({name, "_len"}, 32'(hs), 32'(exp_len));
    checkOutput({name, "_grant_stable"}, 32'(chg), 32'd0);
    if (done && exp_task < NT) exp_pkts[exp_task]++;
    last_low = low;
  endtask

  task automatic check_reset_outputs(input string name);
    checkOutput({name, "_m_valid"}, 32'(m_valid_o), 32'd0);
    checkOutput({name, "_m_last"}, 32'(m_last_o), 32'd0);
    checkOutput({name, "_req_ready"}, 32'(req_ready_o), 32'd0);
    checkOutput({name, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({name, "_m_task"}, 32'(m_task_o), 32'd0);
    checkOutput({name, "_m_data"}, 32'(m_data_o), 32'd0);
`ifdef TASK_ARB_PKT_CNT_EN
    for (int t = 0; t < NT; t++)
      checkOutput($sformatf("%s_pkt_cnt%0d", name, t), 32'(pkt_cnt_o[t*16 +: 16]), 32'd0);
`endif
  endtask

  initial begin
    vec_t vecs [13];
    bit   any_busy;
    int   base;
    int   cyc;

    for (int t = 0; t < NT; t++) begin
      src_cnt[t]  = 0;
      exp_pkts[t] = 0;
    end
    for (int i = 0; i < NT; i++) vecs[i] = '{10'h3FF, 10'h3FF, i, sizes[i]};
    vecs[10] = '{10'h3FF, 10'h3FF, 0, 81};
    vecs[11] = '{10'h3FD, 10'h00A, 3, 120};
    vecs[12] = '{10'h3FF, 10'h004, 2, 27};

    rst_n = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].en, vecs[i].valid, 1'b1);
      run_packet(vecs[i].exp_task, vecs[i].exp_len, $sformatf("vec%0d", i));
    end

    // Enable for the granted task drops mid-packet; the packet still runs to its end.
    applyStimulus(10'h008, 10'h008, 1'b1);
    fork
      run_packet(3, 120, "dis_mid");
      begin
        repeat (20) @(posedge clk);
        #2;
        task_en_i[3] = 1'b0;
      end
    join
    any_busy = 1'b0;
    repeat (5) begin
      step();
      if (s_busy) any_busy = 1'b1;
    end
    checkOutput("dis_no_regrant", 32'(any_busy), 32'd0);

    // Requester stalls for five cycles after its 40th byte.
    applyStimulus(10'h3FF, 10'h001, 1'b1);
    drop_task = 0;
    drop_at   = src_cnt[0] + 40;
    drop_left = 5;
    run_packet(0, 81, "drop");
    checkOutput("drop_low_cycles", 32'(last_low), 32'd5);
    drop_task = -1;

    // Downstream ready toggles every cycle across the 256-byte packet.
    applyStimulus(10'h3FF, 10'h010, 1'b1);
    toggle_ready = 1'b1;
    run_packet(4, 256, "toggle");
    toggle_ready = 1'b0;
    m_ready_i    = 1'b1;

`ifdef TASK_ARB_PKT_CNT_EN
    for (int t = 0; t < NT; t++)
      checkOutput($sformatf("pkt_cnt%0d", t), 32'(pkt_cnt_o[t*16 +: 16]), 32'(exp_pkts[t]));
`endif

    // Reset lands after ten bytes of task 7.
    applyStimulus(10'h080, 10'h080, 1'b1);
    base = src_cnt[7];
    cyc  = 0;
    while (src_cnt[7] < base + 10 && cyc < 500) begin
      step();
      cyc++;
    end
    checkOutput("rst_mid_bytes", 32'(src_cnt[7] - base), 32'd10);
    checkOutput("rst_mid_busy_before", 32'(busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    applyStimulus(10'h3FF, 10'h021, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_packet(0, 81, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/task_pkt_arbiter.md
TASK_PKT_ARBITER -- requirements
Module: task_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_TASKS, default 10: number of task requesters, indices 0..9 map to tasks 1..10.
REQ-002 SHALL have parameter DATA_W, default 8: byte lane width.
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port task_en_i  input  NUM_TASKS: per-task arbitration enable.
REQ-006 SHALL have port req_valid_i  input  NUM_TASKS: per-task byte valid.
REQ-007 SHALL have port req_data_i  input  NUM_TASKS*DATA_W: per-task byte, task i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready_o  output  NUM_TASKS: per-task byte accept.
REQ-009 SHALL have port m_valid_o  output  1: merged stream valid.
REQ-010 SHALL have port m_data_o  output  DATA_W: merged stream byte.
REQ-011 SHALL have port m_last_o  output  1: final byte of packet.
REQ-012 SHALL have port m_task_o  output  4: granted task index (0-based).
REQ-013 SHALL have port m_ready_i  input  1: downstream accept.
REQ-014 SHALL have port busy_o  output  1: packet in progress.

Function
REQ-015 SHALL implement FSM states IDLE and XFER.
REQ-016 In IDLE, SHALL compute candidates = req_valid_i & task_en_i; if non-zero, SHALL register grant = first candidate at or after (last_grant+1) mod NUM_TASKS, clear byte counter, go XFER next cycle.
REQ-017 In IDLE, SHALL drive m_valid_o=0, req_ready_o=0, busy_o=0.
REQ-018 In XFER, SHALL pass through combinationally: m_valid_o=req_valid_i[grant], m_data_o=task grant byte, req_ready_o[grant]=m_ready_i, all other req_ready_o bits 0, busy_o=1.
REQ-019 Handshake = m_valid_o & m_ready_i; byte counter (9 bits) SHALL increment once per handshake only.
REQ-020 Packet length SHALL be the shared-package size of the granted task (81,81,27,120,256,50,50,160,40,64 bytes).
REQ-021 m_last_o SHALL be 1 iff XFER and counter == size-1 and m_valid_o=1.
REQ-022 On last-byte handshake, SHALL set last_grant=grant and return to IDLE; exactly one IDLE cycle SHALL separate consecutive packets.
REQ-023 Requester dropping valid mid-packet SHALL stall the merged stream; no abort, no timeout.
REQ-024 Clearing task_en_i[grant] mid-packet SHALL NOT abort; enable affects only next arbitration.
REQ-025 256-byte packet SHALL complete without counter wrap (counter 255 marks last).
REQ-026 m_task_o SHALL hold grant during XFER and the last grant in IDLE.

Reset
REQ-027 On rst_n=0, SHALL enter IDLE asynchronously; grant=0, last_grant=NUM_TASKS-1 (first arbitration favours task 0), counter=0.
REQ-028 Outputs during/after reset: m_valid_o=0, m_last_o=0, req_ready_o=0, busy_o=0, m_task_o=0, m_data_o=0.
REQ-029 Reset mid-packet SHALL discard remaining bytes; no m_last_o issued.

Configuration
REQ-030 Macro TASK_ARB_PKT_CNT_EN defined: SHALL add output pkt_cnt_o (NUM_TASKS*16), per-task completed-packet counters, +1 on last-byte handshake, wrap at 65535->0, reset to 0.
REQ-031 Macro undefined: port pkt_cnt_o and counters SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package task_pkg SHALL hold existing per-task size constants plus NUM_TASKS constant, task_id_t (4-bit) typedef and a size lookup function (task_id_t -> 12-bit size).
REQ-033 SHALL instantiate one sub-module task_rr_picker: combinational round-robin priority select (candidates, last_grant -> grant, found).

Verification
REQ-034 Only task 2 (idx 2) valid continuously, m_ready_i=1 -> 27 bytes, m_last_o on byte 27, m_task_o=2, then busy_o=0 one cycle.
REQ-035 All 10 tasks valid, enabled -> grant order 0,1,2,...,9,0; each packet length matches table.
REQ-036 Task 4 (256 B) with m_ready_i toggling 1/0 every cycle -> exactly 256 handshakes, no duplicated/dropped byte, last at count 255.
REQ-037 Task 0 drops valid for 5 cycles at byte 40 -> m_valid_o low 5 cycles, no grant change, 81 bytes total.
REQ-038 task_en_i=0 for task 1, tasks 1 and 3 valid -> only task 3 granted; disable task 3 mid-packet -> packet completes.
REQ-039 rst_n low at byte 10 of task 7 -> outputs to reset values immediately; after release with task 0 valid, task 0 granted first; pkt_cnt_o (if enabled) all 0.
